// File: rtl/ctrl_decode_pipe.sv
// RV32I/M instruction decoder with a registered ID/EX control bundle, valid/ready
// handshake, load-use stall and flush. Define CTRL_ILLEGAL_TRAP_EN to pass illegal ops downstream.
module ctrl_decode_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter bit          RV32M_EN = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic             ex_reg_wr,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic [1:0]       ex_wb_ctrl,
  output logic [1:0]       ex_alu_s1,
  output logic             ex_alu_s2,
  output logic [4:0]       ex_alu_op,
  output logic             ex_is_branch,
  output logic             ex_is_jump,
  output logic [2:0]       ex_branch_ctrl,
  output logic [2:0]       ex_mem_ctrl,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [XLEN-1:0]  ex_imm,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_reg_wr, w_mem_rd, w_mem_wr, w_alu_s2, w_is_branch, w_is_jump, w_ill;
  logic [1:0]  w_wb, w_alu_s1;
  logic [4:0]  w_alu_op;
  logic [2:0]  w_branch_ctrl, w_mem_ctrl;
  logic        w_rs1_used, w_rs2_used;
  logic [31:0] w_imm32;
  logic        w_hazard, w_accept, w_load;

  logic             r_valid, r_reg_wr, r_mem_rd, r_mem_wr, r_alu_s2, r_is_branch, r_is_jump;
  logic [1:0]       r_wb, r_alu_s1;
  logic [4:0]       r_alu_op, r_rd, r_rs1, r_rs2;
  logic [2:0]       r_branch_ctrl, r_mem_ctrl;
  logic [XLEN-1:0]  r_imm;
  logic [CNT_W-1:0] r_stall;

  assign w_f3  = instr[14:12];
  assign w_f7  = instr[31:25];
  assign w_rd  = instr[11:7];
  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];

  // NOTE: every decode output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_reg_wr      = 1'b0;
    w_mem_rd      = 1'b0;
    w_mem_wr      = 1'b0;
    w_wb          = 2'b00;
    w_alu_s1      = 2'b01;
    w_alu_s2      = 1'b0;
    w_alu_op      = 5'b00000;
    w_is_branch   = 1'b0;
    w_is_jump     = 1'b0;
    w_branch_ctrl = 3'b000;
    w_mem_ctrl    = 3'b000;
    w_ill         = 1'b0;
    w_rs1_used    = 1'b1;
    w_rs2_used    = 1'b0;
    w_imm32       = 32'h0;
    unique case (instr[6:0])
      OP_R: begin
        w_reg_wr   = 1'b1;
        w_alu_s2   = 1'b1;
        w_wb       = 2'b01;
        w_rs2_used = 1'b1;
        if (w_f7 == 7'b0000001) begin
          if (RV32M_EN) w_alu_op = {2'b10, w_f3};
          else          w_ill    = 1'b1;
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_alu_op = {2'b01, w_f3};
        end else if (w_f7 == 7'b0000000) begin
          w_alu_op = {2'b00, w_f3};
        end else begin
          w_ill = 1'b1;
        end
      end
      OP_I: begin
        w_reg_wr = 1'b1;
        w_wb     = 2'b01;
        w_imm32  = {{20{instr[31]}}, instr[31:20]};
        w_alu_op = {2'b00, w_f3};
        // Shift-immediates carry a funct7 in the immediate field; only SRAI may set bit 5.
        if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_ill = 1'b1;
        if (w_f3 == 3'b101) begin
          if (w_f7 == 7'b0100000)      w_alu_op = {2'b01, w_f3};
          else if (w_f7 != 7'b0000000) w_ill    = 1'b1;
        end
      end
      OP_LOAD: begin
        w_reg_wr = 1'b1;
        w_mem_rd = 1'b1;
        w_imm32  = {{20{instr[31]}}, instr[31:20]};
        case (w_f3)
          3'b000:  w_mem_ctrl = 3'b000;
          3'b001:  w_mem_ctrl = 3'b001;
          3'b010:  w_mem_ctrl = 3'b010;
          3'b100:  w_mem_ctrl = 3'b011;
          3'b101:  w_mem_ctrl = 3'b100;
          default: w_ill      = 1'b1;
        endcase
      end
      OP_STORE: begin
        w_mem_wr   = 1'b1;
        w_rs2_used = 1'b1;
        w_imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        case (w_f3)
          3'b000:  w_mem_ctrl = 3'b101;
          3'b001:  w_mem_ctrl = 3'b110;
          3'b010:  w_mem_ctrl = 3'b111;
          default: w_ill      = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        w_is_branch   = 1'b1;
        w_alu_s2      = 1'b1;
        w_alu_op      = 5'b01000;
        w_branch_ctrl = w_f3;
        w_rs2_used    = 1'b1;
        w_imm32       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_reg_wr   = 1'b1;
        w_wb       = 2'b01;
        w_alu_s1   = (instr[6:0] == OP_LUI) ? 2'b10 : 2'b00;
        w_rs1_used = 1'b0;
        w_imm32    = {instr[31:12], 12'h000};
      end
      OP_JAL: begin
        w_reg_wr   = 1'b1;
        w_is_jump  = 1'b1;
        w_wb       = 2'b10;
        w_alu_s1   = 2'b00;
        w_rs1_used = 1'b0;
        w_imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        w_reg_wr  = 1'b1;
        w_is_jump = 1'b1;
        w_wb      = 2'b10;
        w_imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      default: begin
        w_ill      = 1'b1;
        w_rs1_used = 1'b0;
      end
    endcase
    if (w_ill) begin
      w_reg_wr    = 1'b0;
      w_mem_rd    = 1'b0;
      w_mem_wr    = 1'b0;
      w_is_branch = 1'b0;
      w_is_jump   = 1'b0;
    end
  end

  assign w_hazard = r_valid & r_mem_rd & (r_rd != 5'd0) &
                    (((r_rd == w_rs1) & w_rs1_used) | ((r_rd == w_rs2) & w_rs2_used));
  assign if_ready = flush | (~w_hazard & (~r_valid | ex_ready));
  assign w_accept = if_valid & if_ready & ~flush;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign w_load     = w_accept;
  assign ex_illegal = r_illegal & r_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_illegal <= 1'b0;
    else if (w_load) r_illegal <= w_ill;
  end
`else
  assign w_load     = w_accept & ~w_ill;
  assign ex_illegal = 1'b0;
`endif

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_reg_wr      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_wb          <= 2'b00;
      r_alu_s1      <= 2'b00;
      r_alu_s2      <= 1'b0;
      r_alu_op      <= 5'd0;
      r_is_branch   <= 1'b0;
      r_is_jump     <= 1'b0;
      r_branch_ctrl <= 3'd0;
      r_mem_ctrl    <= 3'd0;
      r_rd          <= 5'd0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_imm         <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      // An illegal op without trap support is consumed but leaves a bubble.
      r_valid <= w_load;
      if (w_load) begin
        r_reg_wr      <= w_reg_wr;
        r_mem_rd      <= w_mem_rd;
        r_mem_wr      <= w_mem_wr;
        r_wb          <= w_wb;
        r_alu_s1      <= w_alu_s1;
        r_alu_s2      <= w_alu_s2;
        r_alu_op      <= w_alu_op;
        r_is_branch   <= w_is_branch;
        r_is_jump     <= w_is_jump;
        r_branch_ctrl <= w_branch_ctrl;
        r_mem_ctrl    <= w_mem_ctrl;
        r_rd          <= w_rd;
        r_rs1         <= w_rs1;
        r_rs2         <= w_rs2;
        r_imm         <= XLEN'($signed(w_imm32));
      end
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (w_hazard && !flush && r_stall != '1)
      r_stall <= r_stall + CNT_W'(1);
  end

  assign ex_valid       = r_valid;
  assign ex_reg_wr      = r_reg_wr & r_valid;
  assign ex_mem_rd      = r_mem_rd & r_valid;
  assign ex_mem_wr      = r_mem_wr & r_valid;
  assign ex_is_branch   = r_is_branch & r_valid;
  assign ex_is_jump     = r_is_jump & r_valid;
  assign ex_wb_ctrl     = r_wb;
  assign ex_alu_s1      = r_alu_s1;
  assign ex_alu_s2      = r_alu_s2;
  assign ex_alu_op      = r_alu_op;
  assign ex_branch_ctrl = r_branch_ctrl;
  assign ex_mem_ctrl    = r_mem_ctrl;
  assign ex_rd          = r_rd;
  assign ex_rs1         = r_rs1;
  assign ex_rs2         = r_rs2;
  assign ex_imm         = r_imm;
  assign stall_count    = r_stall;

endmodule
